// File: rtl/data_bus_responder_if.sv
// Data-port bus between the datapath and the responder, plus the byte stream
// toward the external consumer of the output FIFO.
interface data_bus_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output MemWrite, Addr, WriteData, out_ready,
    input  ReadData, out_data, out_valid
  );

  modport slave (
    input  MemWrite, Addr, WriteData, out_ready,
    output ReadData, out_data, out_valid
  );
endinterface

// File: rtl/data_bus_responder.sv
// Memory-side responder: word RAM, cycle counter, output byte FIFO and status
// register, decoded from the datapath's byte address with combinational reads.
module data_bus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_bus_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [29:0] WA_FIFO = 30'h400;
  localparam logic [29:0] WA_STAT = 30'h401;
  localparam logic [29:0] WA_CNT  = 30'h402;

  // ---------------- address decode ----------------
  logic [29:0] wa;
  logic        sel_ram, sel_fifo, sel_stat, sel_cnt;
  logic        unused_addr_lsb;

  assign wa              = bus.Addr[31:2];
  assign unused_addr_lsb = ^bus.Addr[1:0];
  assign sel_ram  = (bus.Addr[31:AW+2] == '0);
  assign sel_fifo = (wa == WA_FIFO);
  assign sel_stat = (wa == WA_STAT);
  assign sel_cnt  = (wa == WA_CNT);

  // ---------------- RAM (no reset, contents undefined until written) ----------------
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (bus.MemWrite && sel_ram)
      mem[bus.Addr[AW+1:2]] <= bus.WriteData;
  end

  // ---------------- cycle counter ----------------
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (bus.MemWrite && sel_cnt) cnt <= bus.WriteData;
    else                             cnt <= cnt + 32'd1;
  end

  // ---------------- output FIFO ----------------
  logic [7:0]    fbuf [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          ovf;
  logic          full, empty, push, pop, push_ok, ovf_set, ovf_clr;

  assign full    = (count == FIFO_DEPTH[PW:0]);
  assign empty   = (count == '0);
  assign pop     = !empty && bus.out_ready;
  assign push    = bus.MemWrite && sel_fifo;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_clr = bus.MemWrite && sel_stat && bus.WriteData[2];

  always_ff @(posedge clk) begin
    if (push_ok)
      fbuf[wr_ptr] <= bus.WriteData[7:0];
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Gate the head with empty so reset shows zero without clearing storage.
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 8'h00 : fbuf[rd_ptr];

  // ---------------- read mux ----------------
  logic [31:0] status;

  assign status = {16'h0, 8'(count), 5'h0, ovf, empty, full};

  always_comb begin
    bus.ReadData = '0;
    if (sel_ram)       bus.ReadData = mem[bus.Addr[AW+1:2]];
    else if (sel_stat) bus.ReadData = status;
    else if (sel_cnt)  bus.ReadData = cnt;
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed plan steps followed by a randomized phase, all scored against a
// queue/array reference model of the address map.
module tb_data_bus_responder;
  localparam int RW = 64;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_bus_responder_if bus();
  data_bus_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] m_ram [RW];
  bit          m_rv  [RW];
  logic [31:0] m_cnt;
  logic [7:0]  m_q [$];
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rd(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] w;
    bit known;
    w = {a[31:2], 2'b00};
    v = '0;
    known = 1'b1;
    if (w < RW * 4) begin
      known = m_rv[w / 4];
      v     = m_ram[w / 4];
    end else if (w == 32'h1004) begin
      v = {16'h0, 8'(m_q.size()), 5'h0, m_ovf, (m_q.size() == 0), (m_q.size() == FD)};
    end else if (w == 32'h1008) begin
      v = m_cnt;
    end
    return known;
  endfunction

  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    logic [31:0] w;
    bit pop, full, push, clr;
    w    = {a[31:2], 2'b00};
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() == FD);
    push = we && (w == 32'h1000);
    clr  = we && (w == 32'h1004) && wd[2];
    if (pop) void'(m_q.pop_front());
    if (push && (!full || pop)) m_q.push_back(wd[7:0]);
    if (push && full && !pop) m_ovf = 1'b1;
    else if (clr)             m_ovf = 1'b0;
    m_cnt = (we && w == 32'h1008) ? wd : m_cnt + 32'd1;
    if (we && w < RW * 4) begin
      m_ram[w / 4] = wd;
      m_rv[w / 4]  = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_cnt = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // One bus cycle: drive after the falling edge, check mid-low-phase, then
  // advance the model on the rising edge.
  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy,
                     output logic [31:0] rd);
    logic [31:0] e;
    bit known;
    bus.MemWrite  = we;
    bus.Addr      = a;
    bus.WriteData = wd;
    bus.out_ready = rdy;
    #1;
    rd    = bus.ReadData;
    known = exp_rd(a, e);
    if (known) chk("rdata", rd, e);
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
    @(posedge clk);
    if (rst) model_edge(we, a, wd, rdy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ra, rwd;
    bit rwe, rrdy;

    bus.MemWrite  = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // reset state
    @(negedge clk);
    bus.Addr = 32'h1004; #1;
    chk("rst_status", bus.ReadData, 32'h0000_0002);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_odata", 32'(bus.out_data), 32'h0);
    bus.Addr = 32'h1008; #1;
    chk("rst_cnt", bus.ReadData, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // counter after 5 edges, then wrap
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0000_3000, '0, 1'b0, r);
    cyc(1'b0, 32'h1008, '0, 1'b0, r);
    chk("cnt_5", r, 32'd5);
    cyc(1'b1, 32'h1008, 32'hFFFF_FFFE, 1'b0, r);
    cyc(1'b0, 32'h1008, '0, 1'b0, r); chk("cnt_fffe", r, 32'hFFFF_FFFE);
    cyc(1'b0, 32'h1008, '0, 1'b0, r); chk("cnt_ffff", r, 32'hFFFF_FFFF);
    cyc(1'b0, 32'h1008, '0, 1'b0, r); chk("cnt_wrap", r, 32'h0);

    // RAM and unmapped
    cyc(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, r);
    cyc(1'b1, 32'h14, 32'h1234_5678, 1'b0, r);
    cyc(1'b0, 32'h10, '0, 1'b0, r); chk("ram_10", r, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h13, '0, 1'b0, r); chk("ram_13", r, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h14, '0, 1'b0, r); chk("ram_14", r, 32'h1234_5678);
    cyc(1'b0, 32'h2000, '0, 1'b0, r); chk("unmapped_rd", r, 32'h0);
    cyc(1'b1, 32'h2000, 32'hA5A5_A5A5, 1'b0, r);
    cyc(1'b0, 32'h2000, '0, 1'b0, r); chk("unmapped_rd2", r, 32'h0);
    cyc(1'b0, 32'h10, '0, 1'b0, r); chk("ram_10_kept", r, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h1004, '0, 1'b0, r); chk("unmapped_status", r, 32'h0000_0002);

    // FIFO order with stall
    cyc(1'b1, 32'h1000, 32'h41, 1'b0, r);
    cyc(1'b1, 32'h1000, 32'h42, 1'b0, r);
    cyc(1'b1, 32'h1000, 32'h43, 1'b0, r);
    cyc(1'b0, 32'h1004, '0, 1'b0, r); chk("fifo3_status", r, 32'h0000_0300);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, '0, 1'b0, r);
      chk("stall_head", 32'(bus.out_data), 32'h41);
    end
    cyc(1'b0, 32'h0, '0, 1'b1, r); chk("drain_42", 32'(bus.out_data), 32'h42);
    cyc(1'b0, 32'h0, '0, 1'b1, r); chk("drain_43", 32'(bus.out_data), 32'h43);
    cyc(1'b0, 32'h0, '0, 1'b1, r); chk("drain_empty", 32'(bus.out_valid), 32'h0);
    cyc(1'b0, 32'h1004, '0, 1'b0, r); chk("drain_status", r, 32'h0000_0002);

    // full / overflow
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'h1000, 32'(i), 1'b0, r);
    cyc(1'b0, 32'h1004, '0, 1'b0, r); chk("ovf_status", r, 32'h0000_0805);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", 32'(bus.out_data), 32'(i));
      cyc(1'b0, 32'h0, '0, 1'b1, r);
    end
    cyc(1'b1, 32'h1004, 32'h4, 1'b0, r);
    cyc(1'b0, 32'h1004, '0, 1'b0, r); chk("ovf_clear", r, 32'h0000_0002);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h1000, 32'(8'h80 + i), 1'b0, r);
    cyc(1'b1, 32'h1000, 32'h99, 1'b1, r);
    cyc(1'b0, 32'h1004, '0, 1'b0, r); chk("full_pushpop", r, 32'h0000_0801);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, '0, 1'b1, r);

    // async reset mid-operation
    cyc(1'b1, 32'h1000, 32'h31, 1'b0, r);
    cyc(1'b1, 32'h1000, 32'h32, 1'b0, r);
    cyc(1'b1, 32'h1000, 32'h33, 1'b0, r);
    cyc(1'b1, 32'h1008, 32'd100, 1'b0, r);
    bus.MemWrite = 1'b0; bus.Addr = 32'h1008; #1;
    chk("cnt_100", bus.ReadData, 32'd100);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_cnt", bus.ReadData, 32'h0);
    bus.Addr = 32'h1004; #1;
    chk("arst_status", bus.ReadData, 32'h0000_0002);
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.Addr = 32'h1008; #1;
    chk("arst_hold_cnt", bus.ReadData, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h1004, '0, 1'b1, r);
    chk("arst_nopop", 32'(bus.out_valid), 32'h0);
    cyc(1'b0, 32'h1008, '0, 1'b0, r); chk("arst_cnt_run", r, 32'd3);

    // empty push / pop
    cyc(1'b1, 32'h1000, 32'h55, 1'b1, r);
    chk("empty_push_valid", 32'(bus.out_valid), 32'h1);
    chk("empty_push_data", 32'(bus.out_data), 32'h55);
    cyc(1'b0, 32'h0, '0, 1'b1, r);
    chk("empty_pop_valid", 32'(bus.out_valid), 32'h0);
    cyc(1'b0, 32'h1004, '0, 1'b1, r); chk("empty_pop_status", r, 32'h0000_0002);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    ra = 32'($urandom_range(0, RW * 4 - 1));
        2:       ra = 32'h1000 | 32'($urandom_range(0, 3));
        3:       ra = 32'h1004 | 32'($urandom_range(0, 3));
        4:       ra = 32'h1008 | 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      rwe  = ($urandom_range(0, 2) == 0);
      if (ra[31:2] == 30'h402) rwe = rwe && ($urandom_range(0, 3) == 0);
      rwd  = $urandom;
      rrdy = ($urandom_range(0, 2) == 0);
      cyc(rwe, ra, rwd, rrdy, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
